// File: rtl/fpu_pkg.sv
// Shared FSM state type and FP32 field constants for the sequential multiplier.
package fpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        MUL,
        NORM,
        DONE
    } state_t;

    localparam int unsigned FP32_BIAS = 127;
    localparam int unsigned EXP_W     = 8;
    localparam int unsigned MANT_W    = 23;

    localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
    localparam logic [30:0] FP32_INF_MAG = 31'h7F80_0000;

endpackage

// File: rtl/fpu_round_pack.sv
// Normalise, round and pack a 48-bit mantissa product into FP32.
// Build option FPU_MUL_RNE_EN selects round-to-nearest-even; otherwise truncate.
module fpu_round_pack
    import fpu_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exponent,
    input  logic [47:0]       product,
    output logic [31:0]       result,
    output logic              overflow,
    output logic              underflow
);

`ifdef FPU_MUL_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic signed [9:0]   exp_norm;
    logic signed [9:0]   exp_final;
    logic [MANT_W-1:0]   mant;
    logic                guard;
    logic                sticky;
    logic                inc;
    logic [MANT_W:0]     rounded;

    always_comb begin
        exp_norm = exponent;
        mant     = product[45:23];
        guard    = product[22];
        sticky   = |product[21:0];
        if (product[47]) begin
            exp_norm = exponent + 10'sd1;
            mant     = product[46:24];
            guard    = product[23];
            sticky   = |product[22:0];
        end

        inc     = RNE & guard & (sticky | mant[0]);
        rounded = {1'b0, mant} + {{MANT_W{1'b0}}, inc};

        // Carry-out means 1.111..1 rounded up to 10.000..0: mantissa field is already zero.
        exp_final = rounded[MANT_W] ? exp_norm + 10'sd1 : exp_norm;

        overflow  = 1'b0;
        underflow = 1'b0;
        if (exp_final >= 10'sd255) begin
            result   = {sign, FP32_INF_MAG};
            overflow = 1'b1;
        end else if (exp_final <= 10'sd0) begin
            result    = {sign, 31'b0};
            underflow = 1'b1;
        end else begin
            result = {sign, exp_final[EXP_W-1:0], rounded[MANT_W-1:0]};
        end
    end

endmodule

// File: rtl/fpu_mul_seq.sv
// Multi-cycle FP32 multiplier: shift-add mantissa product, BITS_PER_CYCLE bits per MUL cycle.
// Rounding mode is chosen in fpu_round_pack via FPU_MUL_RNE_EN.
module fpu_mul_seq
    import fpu_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        invalid,
    output logic        overflow,
    output logic        underflow
);

    localparam int unsigned N    = 24 / BITS_PER_CYCLE;
    localparam logic [4:0]  LAST = 5'(N - 1);

    state_t            state;
    logic [31:0]       a_q, b_q;
    logic              sign_q;
    logic signed [9:0] exp_q;
    logic [47:0]       mcand;
    logic [23:0]       mplier;
    logic [47:0]       acc;
    logic [4:0]        cnt;

    logic [EXP_W-1:0]  ea, eb;
    logic [MANT_W-1:0] fa, fb;
    logic              sign_u;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic signed [9:0] exp_sum;
    logic              special, special_inv;
    logic [31:0]       special_res;
    logic [47:0]       partial;
    logic [31:0]       rp_result;
    logic              rp_overflow, rp_underflow;

    assign ea     = a_q[30:23];
    assign eb     = b_q[30:23];
    assign fa     = a_q[22:0];
    assign fb     = b_q[22:0];
    assign sign_u = a_q[31] ^ b_q[31];
    assign a_nan  = (ea == '1) && (fa != '0);
    assign b_nan  = (eb == '1) && (fb != '0);
    assign a_inf  = (ea == '1) && (fa == '0);
    assign b_inf  = (eb == '1) && (fb == '0);
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(10'(FP32_BIAS));

    always_comb begin
        special     = 1'b1;
        special_inv = 1'b0;
        special_res = {sign_u, 31'b0};
        if (a_nan || b_nan) begin
            special_res = FP32_QNAN;
            special_inv = 1'b1;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            special_res = FP32_QNAN;
            special_inv = 1'b1;
        end else if (a_inf || b_inf) begin
            special_res = {sign_u, FP32_INF_MAG};
        end else if (a_zero || b_zero) begin
            special_res = {sign_u, 31'b0};
        end else begin
            special = 1'b0;
        end
    end

    // Multiplicand is pre-shifted each cycle, so only the low multiplier bits are examined.
    always_comb begin
        partial = '0;
        for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
            if (mplier[j]) partial = partial + (mcand << j);
        end
    end

    fpu_round_pack u_round_pack (
        .sign      (sign_q),
        .exponent  (exp_q),
        .product   (acc),
        .result    (rp_result),
        .overflow  (rp_overflow),
        .underflow (rp_underflow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            invalid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        busy      <= 1'b1;
                        invalid   <= 1'b0;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        state     <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_q <= sign_u;
                    exp_q  <= exp_sum;
                    mcand  <= {24'b0, 1'b1, fa};
                    mplier <= {1'b1, fb};
                    acc    <= '0;
                    cnt    <= '0;
                    if (special) begin
                        result  <= special_res;
                        invalid <= special_inv;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc    <= acc + partial;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= NORM;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                NORM: begin
                    result    <= rp_result;
                    overflow  <= rp_overflow;
                    underflow <= rp_underflow;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_mul_seq.sv
// Directed-vector bench for fpu_mul_seq at BITS_PER_CYCLE 1 and 4.
module tb_fpu_mul_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start1 = 1'b0, start4 = 1'b0;
    logic [31:0] a1 = '0, b1 = '0, a4 = '0, b4 = '0;
    logic        busy1, done1, inv1, ovf1, unf1;
    logic        busy4, done4, inv4, ovf4, unf4;
    logic [31:0] result1, result4;

    int vectors = 0;
    int miscompares = 0;
    bit sel4 = 1'b0;

    logic        m_busy, m_done;
    logic [31:0] m_result;
    logic [2:0]  m_flags;

`ifdef FPU_MUL_RNE_EN
    localparam logic [31:0] TIE_RES = 32'h3FC0_0002;
`else
    localparam logic [31:0] TIE_RES = 32'h3FC0_0001;
`endif

    always #5 clk = ~clk;

    fpu_mul_seq #(.BITS_PER_CYCLE(1)) dut (
        .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(result1),
        .invalid(inv1), .overflow(ovf1), .underflow(unf1)
    );

    fpu_mul_seq #(.BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(result4),
        .invalid(inv4), .overflow(ovf4), .underflow(unf4)
    );

    assign m_busy   = sel4 ? busy4 : busy1;
    assign m_done   = sel4 ? done4 : done1;
    assign m_result = sel4 ? result4 : result1;
    assign m_flags  = sel4 ? {inv4, ovf4, unf4} : {inv1, ovf1, unf1};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic s);
        if (sel4) begin
            a4 = av; b4 = bv; start4 = s;
        end else begin
            a1 = av; b1 = bv; start1 = s;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] want_res, input logic [2:0] want_flags, input int lat);
        int cyc = 1;
        @(negedge clk);
        drive(av, bv, 1'b1);
        @(posedge clk); #1;
        // Garbage operands while busy must not disturb the captured ones.
        drive(32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        check_eq({tag, " busy"}, 64'(m_busy), 64'd1);
        while (!m_done && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq({tag, " latency"}, 64'(cyc), 64'(lat));
        check_eq({tag, " result"}, 64'(m_result), 64'(want_res));
        check_eq({tag, " flags"}, 64'(m_flags), 64'(want_flags));
        @(posedge clk); #1;
        check_eq({tag, " idle"}, 64'({m_busy, m_done}), 64'd0);
    endtask

    initial begin
        int ndone, first, second;
        logic [31:0] res_q;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset state", {27'd0, busy1, done1, result1, inv1, ovf1, unf1}, 64'd0);
        check_eq("reset state bpc4", {27'd0, busy4, done4, result4, inv4, ovf4, unf4}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("2x3",      32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000, 27);
        run_op("1.5sq",    32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 3'b000, 27);
        run_op("tie",      32'h3FC0_0000, 32'h3F80_0001, TIE_RES,       3'b000, 27);
        run_op("inf*0",    32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b100, 2);
        run_op("inf*-2",   32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 3'b000, 2);
        run_op("nan*1",    32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b100, 2);
        run_op("ovf",      32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 3'b010, 27);
        run_op("unf",      32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 3'b001, 27);
        run_op("denorm*2", 32'h8000_0001, 32'h4000_0000, 32'h8000_0000, 3'b000, 2);
        run_op("-1.5*2",   32'hBFC0_0000, 32'h4000_0000, 32'hC040_0000, 3'b000, 27);

        sel4 = 1'b1;
        run_op("bpc4 1.5sq", 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 3'b000, 9);
        run_op("bpc4 2x3",   32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000, 9);
        sel4 = 1'b0;

        // start held high: accepts at cycles 0, 28, 56 -> dones at 27, 55, 83.
        ndone = 0; first = 0; second = 0;
        @(negedge clk);
        a1 = 32'h4000_0000; b1 = 32'h4040_0000; start1 = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 100; c++) begin
            if (c == 60) start1 = 1'b0;
            if (done1) begin
                ndone++;
                if (first == 0) first = c;
                else if (second == 0) second = c;
            end
            @(posedge clk); #1;
        end
        check_eq("held start done count", 64'(ndone), 64'd3);
        check_eq("held start first done", 64'(first), 64'd27);
        check_eq("back-to-back gap", 64'(second - first), 64'd28);
        check_eq("held start result", 64'(result1), 64'h40C0_0000);
        check_eq("held start idle", 64'(busy1), 64'd0);

        // Reset during cycle T+10 aborts the operation.
        @(negedge clk);
        a1 = 32'h3FC0_0000; b1 = 32'h3FC0_0000; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check_eq("busy before abort", 64'(busy1), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("abort outputs", {27'd0, busy1, done1, result1, inv1, ovf1, unf1}, 64'd0);
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done1 || busy1) ndone++;
        end
        check_eq("abort no done", 64'(ndone), 64'd0);

        // reset and start together: request dropped.
        @(negedge clk);
        reset = 1'b1; start1 = 1'b1; a1 = 32'h4000_0000; b1 = 32'h4040_0000;
        @(posedge clk); #1;
        reset = 1'b0; start1 = 1'b0;
        ndone = 0;
        repeat (40) begin
            if (done1 || busy1) ndone++;
            @(posedge clk); #1;
        end
        check_eq("reset beats start", 64'(ndone), 64'd0);
        res_q = result1;
        check_eq("reset beats start result", 64'(res_q), 64'd0);

        run_op("post reset 2x3", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000, 27);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
